// File: rtl/uart_pattern_matcher.sv
// uart_pattern_matcher
//   Compares the most recent received UART bytes against a runtime-programmable
//   byte pattern. Overlapping occurrences are all reported. Every match produces
//   a one-cycle pulse and advances a saturating match counter.
//
// Ports
//   sys_clk      : system clock; all state changes on the rising edge
//   reset        : synchronous, active-low reset
//   data_in      : received byte (from uart_sampler data_out)
//   data_valid   : one-cycle strobe that qualifies data_in
//   pat_wr_en    : write one pattern byte this cycle
//   pat_wr_addr  : pattern byte index (0 = first byte seen on the line)
//   pat_wr_data  : pattern byte value
//   pat_len      : active pattern length (1..MAX_LEN enables matching)
//   clear_cnt    : zero match_count
//   match        : registered one-cycle pulse when the pattern completes
//   match_count  : saturating count of matches since reset/clear
//   fill         : bytes in the window since the last flush (saturates at MAX_LEN)
module uart_pattern_matcher #(
  parameter  int MAX_LEN = 8,
  parameter  int LEN_W   = 4,
  parameter  int CNT_W   = 16,
  localparam int ADDR_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        data_in,
  input  logic              data_valid,
  input  logic              pat_wr_en,
  input  logic [ADDR_W-1:0] pat_wr_addr,
  input  logic [7:0]        pat_wr_data,
  input  logic [LEN_W-1:0]  pat_len,
  input  logic              clear_cnt,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [LEN_W-1:0]  fill
);

  // When the address field can only encode legal indices, no range check is needed.
  localparam bit ADDR_ALWAYS_OK = ((2 ** ADDR_W) <= MAX_LEN);

  logic [7:0]       win      [MAX_LEN];
  logic [7:0]       pattern  [MAX_LEN];
  logic [7:0]       win_next [MAX_LEN];
  logic [LEN_W-1:0] fill_next;
  logic [CNT_W-1:0] cnt_next;
  logic [ADDR_W-1:0] idx;
  logic             pat_wr_ok;
  logic             enabled;
  logic             hit;

  // NOTE: every variable gets a default at the top of the block so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    win_next  = win;
    fill_next = fill;
    cnt_next  = match_count;
    idx       = '0;
    pat_wr_ok = pat_wr_en && (ADDR_ALWAYS_OK || (int'(pat_wr_addr) < MAX_LEN));
    enabled   = (pat_len != '0) && (int'(pat_len) <= MAX_LEN);

    // Window after the current byte: win_next[0] is the newest byte.
    if (data_valid) begin
      win_next[0] = data_in;
      for (int k = 1; k < MAX_LEN; k++) win_next[k] = win[k-1];
    end

    // A pattern write flushes the window; a byte arriving in the same cycle
    // still counts as the first byte after the flush.
    if (pat_wr_ok)
      fill_next = data_valid ? LEN_W'(1) : '0;
    else if (data_valid && (int'(fill) < MAX_LEN))
      fill_next = fill + LEN_W'(1);

    // Newest byte lines up with the last pattern byte. Compares use the
    // stored pattern, so a write this cycle only takes effect next cycle.
    hit = data_valid && enabled && (int'(fill_next) >= int'(pat_len));
    for (int k = 0; k < MAX_LEN; k++) begin
      if (k < int'(pat_len)) begin
        idx = ADDR_W'(int'(pat_len) - 1 - k);
        if (win_next[k] != pattern[idx]) hit = 1'b0;
      end
    end

    if (clear_cnt)
      cnt_next = hit ? CNT_W'(1) : '0;
    else if (hit && (match_count != {CNT_W{1'b1}}))
      cnt_next = match_count + CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge sys_clk) begin
    if (!reset) begin
      // NOTE: the window and pattern arrays are reset on purpose: a stale
      // pattern or window must never produce a match after reset.
      for (int k = 0; k < MAX_LEN; k++) begin
        win[k]     <= '0;
        pattern[k] <= '0;
      end
      fill        <= '0;
      match       <= 1'b0;
      match_count <= '0;
    end else begin
      win <= win_next;
      if (pat_wr_ok) pattern[pat_wr_addr] <= pat_wr_data;
      fill        <= fill_next;
      match       <= hit;
      match_count <= cnt_next;
    end
  end

endmodule

// File: tb/tb_uart_pattern_matcher.sv
// Directed testbench for uart_pattern_matcher. Two instances share stimulus:
// dut0 uses the default counter width, dut1 a 2-bit counter for saturation.
module tb_uart_pattern_matcher;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        pat_wr_en;
  logic [2:0]  pat_wr_addr;
  logic [7:0]  pat_wr_data;
  logic [3:0]  pat_len;
  logic        clear_cnt;

  logic        match0, match1;
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [3:0]  fill0, fill1;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 sys_clk = ~sys_clk;

  uart_pattern_matcher #(.MAX_LEN(8), .LEN_W(4), .CNT_W(16)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .pat_len(pat_len), .clear_cnt(clear_cnt),
    .match(match0), .match_count(cnt0), .fill(fill0)
  );

  uart_pattern_matcher #(.MAX_LEN(8), .LEN_W(4), .CNT_W(2)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .pat_wr_en(pat_wr_en), .pat_wr_addr(pat_wr_addr), .pat_wr_data(pat_wr_data),
    .pat_len(pat_len), .clear_cnt(clear_cnt),
    .match(match1), .match_count(cnt1), .fill(fill1)
  );

  // Outputs are sampled on the falling edge, half a period after they update.
  always @(negedge sys_clk) if (match0) pulses++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic idle();
    @(negedge sys_clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    pat_wr_en = 1'b1; pat_wr_addr = a; pat_wr_data = d;
    @(negedge sys_clk);
    pat_wr_en = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    data_in = b; data_valid = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0;
  endtask

  task automatic clear();
    clear_cnt = 1'b1;
    @(negedge sys_clk);
    clear_cnt = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge sys_clk);
    reset = 1'b1;
  endtask

  int p0;

  initial begin
    reset = 1'b1; data_in = '0; data_valid = 1'b0; pat_wr_en = 1'b0;
    pat_wr_addr = '0; pat_wr_data = '0; pat_len = '0; clear_cnt = 1'b0;
    @(negedge sys_clk);
    do_reset();
    check("reset_match", 32'(match0), 32'd0);
    check("reset_count", 32'(cnt0), 32'd0);
    check("reset_fill", 32'(fill0), 32'd0);

    // 1. Basic two-byte match
    wr(3'd0, 8'h41); wr(3'd1, 8'h42); pat_len = 4'd2;
    send(8'h41);
    check("t1_no_early_match", 32'(match0), 32'd0);
    send(8'h42);
    check("t1_match", 32'(match0), 32'd1);
    check("t1_count", 32'(cnt0), 32'd1);
    check("t1_fill", 32'(fill0), 32'd2);
    idle();
    check("t1_pulse_ends", 32'(match0), 32'd0);

    // 2. Overlap, back-to-back bytes
    wr(3'd0, 8'h55); wr(3'd1, 8'h55); clear();
    data_in = 8'h55; data_valid = 1'b1;
    @(negedge sys_clk);
    check("t2_byte1", 32'(match0), 32'd0);
    @(negedge sys_clk);
    check("t2_byte2", 32'(match0), 32'd1);
    @(negedge sys_clk);
    data_valid = 1'b0;
    check("t2_byte3", 32'(match0), 32'd1);
    check("t2_count", 32'(cnt0), 32'd2);
    idle();
    check("t2_end", 32'(match0), 32'd0);

    // 3. Pattern straddling a reset never matches
    wr(3'd0, 8'hD6); wr(3'd1, 8'h35); clear();
    send(8'hD6);
    do_reset();
    check("t3_fill_after_reset", 32'(fill0), 32'd0);
    send(8'h35);
    check("t3_no_match", 32'(match0), 32'd0);
    check("t3_count", 32'(cnt0), 32'd0);
    check("t3_fill", 32'(fill0), 32'd1);

    // 4a. pat_len=0 and pat_len>MAX_LEN disable matching
    wr(3'd0, 8'h00); wr(3'd1, 8'h00);
    pat_len = 4'd0;
    p0 = pulses;
    for (int i = 0; i < 20; i++) send(8'((i * 37) & 8'hF0));
    pat_len = 4'd9;
    for (int i = 0; i < 10; i++) send(8'h00);
    check("t4_disabled_pulses", 32'(pulses - p0), 32'd0);
    check("t4_disabled_count", 32'(cnt0), 32'd0);

    // 4b. Full-length pattern 01..08
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(i + 1));
    pat_len = 4'd8;
    p0 = pulses;
    send(8'h00);
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      if (i == 7) check("t4_no_match_at_07", 32'(match0), 32'd0);
    end
    check("t4_full_match", 32'(match0), 32'd1);
    check("t4_fill_sat", 32'(fill0), 32'd8);
    idle();
    check("t4_single_pulse", 32'(pulses - p0), 32'd1);

    // 5. Pattern write flushes the window
    wr(3'd0, 8'h41); wr(3'd1, 8'h42); pat_len = 4'd2; clear();
    send(8'h41);
    wr(3'd1, 8'h42);
    check("t5_flush_fill", 32'(fill0), 32'd0);
    send(8'h42);
    check("t5_no_match", 32'(match0), 32'd0);
    check("t5_fill", 32'(fill0), 32'd1);
    // Write and byte in the same cycle: fill restarts at 1
    send(8'h41);
    data_in = 8'h42; data_valid = 1'b1;
    pat_wr_en = 1'b1; pat_wr_addr = 3'd1; pat_wr_data = 8'h42;
    @(negedge sys_clk);
    data_valid = 1'b0; pat_wr_en = 1'b0;
    check("t5_wr_and_valid_fill", 32'(fill0), 32'd1);
    check("t5_wr_and_valid_match", 32'(match0), 32'd0);

    // 6. Two-bit counter saturation and clear coincident with a match
    wr(3'd0, 8'h7E); pat_len = 4'd1; clear();
    check("t6_cleared", 32'(cnt1), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      send(8'h7E);
      check($sformatf("t6_sat_%0d", i), 32'(cnt1), (i < 3) ? 32'(i) : 32'd3);
    end
    check("t6_wide_count", 32'(cnt0), 32'd5);
    data_in = 8'h7E; data_valid = 1'b1; clear_cnt = 1'b1;
    @(negedge sys_clk);
    data_valid = 1'b0; clear_cnt = 1'b0;
    check("t6_clear_with_match", 32'(cnt1), 32'd1);
    check("t6_clear_match_pulse", 32'(match1), 32'd1);
    idle();
    check("t6_hold", 32'(cnt1), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
